uart_packet_tx: RTL and testbench

Downstream consumer of the sample queue. It pops 8-bit samples from the queue's read side, gathers up to MAX_PAYLOAD of them into a local buffer, and transmits them as a framed packet over a UART 8N1 link to the host: SYNC, LEN, payload, CHK. It is the last stage of the acquisition data path before the physical serial line.

---
 rtl/uart_packet_tx.sv | 230 +++++++++++++++++++++++
 tb/tb_uart_packet_tx.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_packet_tx.sv
// uart_packet_tx
//
// Last stage of the acquisition data path. Pops 8-bit samples from the
// sample queue into a local payload buffer (up to MAX_PAYLOAD bytes),
// then sends them to the host over a UART 8N1 line as one framed packet:
//   SYNC, LEN, payload[0..LEN-1], CHK   with CHK = (LEN + sum(payload)) mod 256
//
// A partial packet is closed once the queue has stayed empty for IDLE_TO
// consecutive cycles while gathering (and at least one byte is held).
//
// Ports
//   ck         in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   q_em       in   queue empty flag
//   q_data     in   queue head byte, valid while q_em=0
//   q_pp       out  pop strobe, one byte consumed per cycle it is high
//   tx         out  UART serial line, idle high
//   busy       out  high from leaving IDLE until the CHK stop bit completes
//   fsm_state  out  current FSM state encoding (debug visibility)
//
// Queue handshake: q_em low means q_data holds a valid byte (the "valid"
// side); q_pp is our combinational "ready/pop". A byte is transferred on
// every rising edge where q_em=0 and q_pp=1, and q_pp is never raised
// while q_em=1 or outside GATHER.

module uart_packet_tx #(
  parameter int         CLK_DIV     = 434,
  parameter int         MAX_PAYLOAD = 16,
  parameter int         IDLE_TO     = 1024,
  parameter logic [7:0] SYNC        = 8'hA5
) (
  input  logic       ck,
  input  logic       rst_n,
  input  logic       q_em,
  input  logic [7:0] q_data,
  output logic       q_pp,
  output logic       tx,
  output logic       busy,
  output logic [2:0] fsm_state
);

  localparam int CW    = $clog2(MAX_PAYLOAD + 1);
  localparam int TW    = $clog2(IDLE_TO + 1);
  // Buffer depth is rounded up to 2**CW so that a CW-bit index covers it
  // exactly; entries at or above MAX_PAYLOAD are never written.
  localparam int DEPTH = 1 << CW;

  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_PAYLOAD);
  localparam logic [TW-1:0] TMR_MAX  = TW'(IDLE_TO);
  localparam logic [15:0]   DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [3:0]    BIT_STOP = 4'd9;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GATHER = 3'd1,
    S_SYNC = 3'd2,
    S_LEN  = 3'd3,
    S_DATA = 3'd4,
    S_CHK  = 3'd5
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [CW-1:0] idx, idx_nxt;
  logic [TW-1:0] tmr, tmr_nxt;
  logic [15:0]   div, div_nxt;
  logic [3:0]    bit_idx, bit_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic [7:0]    sum, sum_nxt;
  logic          tx_nxt;
  logic          frame_end;
  logic          send_nxt;
  logic [7:0]    pbuf [DEPTH];

  // ---------------------------------------------------------------------
  // Next-state, datapath and pop strobe
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    tmr_nxt   = tmr;
    div_nxt   = div;
    bit_nxt   = bit_idx;
    shreg_nxt = shreg;
    sum_nxt   = sum;
    q_pp      = 1'b0;
    frame_end = 1'b0;

    // Bit timer shared by all send states. Bit 0 is the start bit, bits
    // 1..8 are data (shreg[0] is the bit on the line), bit 9 is the stop
    // bit. The shift happens when leaving a data bit so that bit 1 shows
    // the LSB of the freshly loaded byte.
    if (state inside {S_SYNC, S_LEN, S_DATA, S_CHK}) begin
      if (div == DIV_LAST) begin
        div_nxt = 16'd0;
        if (bit_idx == BIT_STOP) begin
          frame_end = 1'b1;
        end else begin
          bit_nxt = bit_idx + 4'd1;
          if (bit_idx != 4'd0) shreg_nxt = shreg >> 1;
        end
      end else begin
        div_nxt = div + 16'd1;
      end
    end

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        tmr_nxt = '0;
        sum_nxt = 8'd0;
        if (!q_em) state_nxt = GATHER;
      end

      GATHER: begin
        q_pp = !q_em && (cnt != CNT_MAX);
        if (q_pp) begin
          cnt_nxt = cnt + CW'(1);
          sum_nxt = sum + q_data;
          tmr_nxt = '0;
        end else if (q_em && (tmr != TMR_MAX)) begin
          tmr_nxt = tmr + TW'(1);
        end
        // Exit is decided on the updated count/timer so that the start
        // bit goes out on the same edge as the last pop or last empty tick.
        if ((cnt_nxt == CNT_MAX) || ((tmr_nxt == TMR_MAX) && (cnt_nxt != '0))) begin
          state_nxt = S_SYNC;
          div_nxt   = 16'd0;
          bit_nxt   = 4'd0;
          shreg_nxt = SYNC;
        end
      end

      S_SYNC: begin
        if (frame_end) begin
          state_nxt = S_LEN;
          bit_nxt   = 4'd0;
          shreg_nxt = 8'(cnt);
        end
      end

      S_LEN: begin
        if (frame_end) begin
          state_nxt = S_DATA;
          bit_nxt   = 4'd0;
          shreg_nxt = pbuf[0];
          idx_nxt   = CW'(1);
        end
      end

      S_DATA: begin
        // idx counts payload bytes already loaded into the shifter.
        if (frame_end) begin
          bit_nxt = 4'd0;
          if (idx == cnt) begin
            state_nxt = S_CHK;
            shreg_nxt = sum + 8'(cnt);
          end else begin
            shreg_nxt = pbuf[idx];
            idx_nxt   = idx + CW'(1);
          end
        end
      end

      S_CHK: begin
        if (frame_end) begin
          state_nxt = IDLE;
          bit_nxt   = 4'd0;
          cnt_nxt   = '0;
          tmr_nxt   = '0;
          sum_nxt   = 8'd0;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    // The line level is computed from next-cycle values so tx can be a
    // glitch-free register that changes on the same edge as the state.
    send_nxt = state_nxt inside {S_SYNC, S_LEN, S_DATA, S_CHK};
    if (!send_nxt) begin
      tx_nxt = 1'b1;
    end else if (bit_nxt == 4'd0) begin
      tx_nxt = 1'b0;
    end else if (bit_nxt == BIT_STOP) begin
      tx_nxt = 1'b1;
    end else begin
      tx_nxt = shreg_nxt[0];
    end
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      tmr     <= '0;
      div     <= 16'd0;
      bit_idx <= 4'd0;
      shreg   <= 8'd0;
      sum     <= 8'd0;
      tx      <= 1'b1;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      idx     <= idx_nxt;
      tmr     <= tmr_nxt;
      div     <= div_nxt;
      bit_idx <= bit_nxt;
      shreg   <= shreg_nxt;
      sum     <= sum_nxt;
      tx      <= tx_nxt;
    end
  end

  // Payload buffer: contents are don't-care after reset.
  always_ff @(posedge ck) begin
    if (q_pp) pbuf[cnt] <= q_data;
  end

  assign busy      = (state != IDLE);
  assign fsm_state = state;

endmodule

// File: tb/tb_uart_packet_tx.sv
// Testbench for uart_packet_tx with CLK_DIV=4, MAX_PAYLOAD=16, IDLE_TO=8.
// A queue model feeds the DUT; a negedge monitor counts pops, busy cycles,
// empty-to-start gaps and decodes tx into rx_q. Each test task compares
// against hand-computed expectations.

module tb_uart_packet_tx;

  logic       ck = 1'b0;
  logic       rst_n = 1'b1;
  logic       q_em = 1'b1;
  logic [7:0] q_data = 8'h00;
  logic       q_pp;
  logic       tx;
  logic       busy;
  logic [2:0] fsm_state;

  uart_packet_tx #(
    .CLK_DIV(4), .MAX_PAYLOAD(16), .IDLE_TO(8), .SYNC(8'hA5)
  ) dut (
    .ck(ck), .rst_n(rst_n), .q_em(q_em), .q_data(q_data),
    .q_pp(q_pp), .tx(tx), .busy(busy), .fsm_state(fsm_state)
  );

  // ---------------- clock ----------------
  always #5 ck = ~ck;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] src_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  bit  pop_req = 0;
  int  pop_cnt = 0, run = 0, max_run = 0, busy_cyc = 0, viol = 0;
  int  frame_err = 0, gap = 0, last_gap = -1;
  bit  gap_track = 0;
  bit  dec_busy = 0;
  int  dec_tick = 0;
  logic [7:0] dec_sh = 8'h00;

  // ---------------- queue model: inputs change 1ns after the edge -------
  always @(posedge ck) begin
    #1;
    if (pop_req && src_q.size() > 0) void'(src_q.pop_front());
    pop_req = 0;
    q_em   = (src_q.size() == 0);
    q_data = q_em ? 8'h00 : src_q[0];
  end

  // ---------------- monitor + UART decoder (CLK_DIV=4) -----------------
  always @(negedge ck) begin
    if (q_pp) begin
      pop_req = 1;
      pop_cnt++;
      run++;
      if (run > max_run) max_run = run;
      gap = 0;
      gap_track = 1;
    end else begin
      run = 0;
      if (gap_track) begin
        if (tx) gap++;
        else begin
          last_gap = gap;
          gap_track = 0;
        end
      end
    end
    if (q_pp && q_em) viol++;
    if (busy) busy_cyc++;

    if (!rst_n) begin
      dec_busy = 0;
    end else if (!dec_busy) begin
      if (!tx) begin
        dec_busy = 1;
        dec_tick = 0;
      end
    end else begin
      dec_tick++;
      if (dec_tick == 2) begin
        if (tx) frame_err++;
      end else if (dec_tick >= 6 && dec_tick <= 34 && (dec_tick % 4) == 2) begin
        dec_sh = {tx, dec_sh[7:1]};
      end else if (dec_tick == 38) begin
        if (!tx) frame_err++;
        rx_q.push_back(dec_sh);
        dec_busy = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_mon();
    @(posedge ck);
    #2;
    pop_cnt = 0; run = 0; max_run = 0; busy_cyc = 0; viol = 0;
    frame_err = 0; gap = 0; last_gap = -1; gap_track = 0;
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_done(input int budget, output bit ok);
    bit seen;
    ok = 0;
    seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge ck);
      if (busy) seen = 1;
      else if (seen) begin
        ok = 1;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx: got %b expected 1", tx); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (q_pp !== 1'b0) begin n_bad++; $display("FAIL reset_q_pp: got %b expected 0", q_pp); end
    n_cmp++; if (fsm_state !== 3'd0) begin n_bad++; $display("FAIL reset_state: got %0d expected 0", fsm_state); end
    repeat (3) @(negedge ck);
    rst_n = 1'b1;
    repeat (10) @(negedge ck);
    n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL idle_tx: got %b expected 1", tx); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_full_packet();
    bit ok;
    clear_mon();
    @(negedge ck);
    for (int i = 0; i < 16; i++) src_q.push_back(8'(i));
    exp_q = '{8'hA5, 8'h10};
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
    exp_q.push_back(8'h88);
    wait_done(2000, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL full_done: got timeout expected busy fall"); end
    n_cmp++; if (pop_cnt != 16) begin n_bad++; $display("FAIL full_pops: got %0d expected 16", pop_cnt); end
    n_cmp++; if (max_run != 16) begin n_bad++; $display("FAIL full_run: got %0d expected 16", max_run); end
    n_cmp++; if (busy_cyc != 776) begin n_bad++; $display("FAIL full_busy: got %0d expected 776", busy_cyc); end
    n_cmp++; if (frame_err != 0) begin n_bad++; $display("FAIL full_frame: got %0d expected 0", frame_err); end
    n_cmp++; if (rx_q.size() != exp_q.size()) begin n_bad++; $display("FAIL full_len: got %0d expected %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      n_cmp++;
      if (rx_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL full_byte%0d: got %h expected %h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    clear_mon();
    @(negedge ck);
    src_q.push_back(8'h01); src_q.push_back(8'h02); src_q.push_back(8'h03);
    exp_q = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'h09};
    wait_done(1000, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL tmo_done: got timeout expected busy fall"); end
    n_cmp++; if (pop_cnt != 3) begin n_bad++; $display("FAIL tmo_pops: got %0d expected 3", pop_cnt); end
    n_cmp++; if (last_gap != 8) begin n_bad++; $display("FAIL tmo_gap: got %0d expected 8", last_gap); end
    n_cmp++; if (rx_q.size() != exp_q.size()) begin n_bad++; $display("FAIL tmo_len: got %0d expected %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      n_cmp++;
      if (rx_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL tmo_byte%0d: got %h expected %h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_checksum_wrap();
    bit ok;
    clear_mon();
    @(negedge ck);
    src_q.push_back(8'hFF); src_q.push_back(8'hFF);
    exp_q = '{8'hA5, 8'h02, 8'hFF, 8'hFF, 8'h00};
    wait_done(1000, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL wrap_done: got timeout expected busy fall"); end
    n_cmp++; if (rx_q.size() != exp_q.size()) begin n_bad++; $display("FAIL wrap_len: got %0d expected %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      n_cmp++;
      if (rx_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL wrap_byte%0d: got %h expected %h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_refill();
    bit ok;
    bit got2;
    clear_mon();
    @(negedge ck);
    src_q.push_back(8'h10); src_q.push_back(8'h20);
    got2 = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge ck);
      if (pop_cnt >= 2) begin got2 = 1; break; end
    end
    n_cmp++; if (!got2) begin n_bad++; $display("FAIL refill_first: got %0d pops expected 2", pop_cnt); end
    repeat (5) @(negedge ck);
    src_q.push_back(8'h30); src_q.push_back(8'h40);
    exp_q = '{8'hA5, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40, 8'hA4};
    wait_done(1000, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL refill_done: got timeout expected busy fall"); end
    n_cmp++; if (pop_cnt != 4) begin n_bad++; $display("FAIL refill_pops: got %0d expected 4", pop_cnt); end
    n_cmp++; if (viol != 0) begin n_bad++; $display("FAIL refill_pop_empty: got %0d expected 0", viol); end
    n_cmp++; if (rx_q.size() != exp_q.size()) begin n_bad++; $display("FAIL refill_len: got %0d expected %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      n_cmp++;
      if (rx_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL refill_byte%0d: got %h expected %h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2;
    clear_mon();
    @(negedge ck);
    for (int i = 0; i < 18; i++) src_q.push_back(8'(8'h20 + i));
    exp_q = '{8'hA5, 8'h10};
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(8'h20 + i));
    exp_q.push_back(8'h88);
    exp_q.push_back(8'hA5); exp_q.push_back(8'h02);
    exp_q.push_back(8'h30); exp_q.push_back(8'h31); exp_q.push_back(8'h63);
    wait_done(2000, ok1);
    wait_done(1000, ok2);
    n_cmp++; if (!(ok1 && ok2)) begin n_bad++; $display("FAIL b2b_done: got %b%b expected 11", ok1, ok2); end
    n_cmp++; if (pop_cnt != 18) begin n_bad++; $display("FAIL b2b_pops: got %0d expected 18", pop_cnt); end
    n_cmp++; if (viol != 0) begin n_bad++; $display("FAIL b2b_pop_empty: got %0d expected 0", viol); end
    n_cmp++; if (frame_err != 0) begin n_bad++; $display("FAIL b2b_frame: got %0d expected 0", frame_err); end
    n_cmp++; if (rx_q.size() != exp_q.size()) begin n_bad++; $display("FAIL b2b_len: got %0d expected %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      n_cmp++;
      if (rx_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL b2b_byte%0d: got %h expected %h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_in_data();
    bit ok;
    bit got4;
    clear_mon();
    @(negedge ck);
    src_q.push_back(8'h11); src_q.push_back(8'h22); src_q.push_back(8'h33);
    got4 = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge ck);
      if (rx_q.size() >= 4) begin got4 = 1; break; end
    end
    n_cmp++; if (!got4) begin n_bad++; $display("FAIL rst_reach: got %0d bytes expected 4", rx_q.size()); end
    // now a few cycles into the third payload frame
    repeat (12) @(negedge ck);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL rst_tx: got %b expected 1", tx); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b expected 0", busy); end
    n_cmp++; if (q_pp !== 1'b0) begin n_bad++; $display("FAIL rst_q_pp: got %b expected 0", q_pp); end
    @(negedge ck);
    #2 rst_n = 1'b1;
    clear_mon();
    repeat (5) @(negedge ck);
    n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL rst_no_resume: got %b expected 1", tx); end
    n_cmp++; if (fsm_state !== 3'd0) begin n_bad++; $display("FAIL rst_state: got %0d expected 0", fsm_state); end
    src_q.push_back(8'h7E);
    exp_q = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
    wait_done(1000, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rst_after_done: got timeout expected busy fall"); end
    n_cmp++; if (rx_q.size() != exp_q.size()) begin n_bad++; $display("FAIL rst_after_len: got %0d expected %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      n_cmp++;
      if (rx_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL rst_after_byte%0d: got %h expected %h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_full_packet();
    test_timeout();
    test_checksum_wrap();
    test_refill();
    test_back_to_back();
    test_reset_in_data();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got no completion expected finish before 600000");
    $fatal(1);
  end

endmodule
